// File: rtl/col_lane_tx.sv
// Packs a serial 2-bit symbol stream into COLS-lane beats; final symbol to oval visible takes 2 cycles.
// ordy low holds the presented beat, the stage absorbs one more beat, then in_ready drops.
module col_lane_tx #(
   parameter int COLS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_data,
   input  logic                  in_last,
   output logic [COLS-1:0]       oval,
   output logic [COLS-1:0][1:0]  odata,
   input  logic                  ordy,
   output logic [15:0]           beat_cnt
);

   localparam int PW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [PW-1:0] LAST_LANE = PW'(COLS - 1);

   typedef struct packed {
      logic [COLS-1:0]      mask;
      logic [COLS-1:0][1:0] data;
   } beat_t;

   typedef enum logic {FILL, FULL} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, ptr_nxt;
   beat_t         stg, stg_nxt;
   beat_t         obuf, obuf_nxt;
   logic          stg_full;
   logic          xfer;
   logic          accept;
   logic          out_hs;

   assign stg_full = (state == FULL);
   assign out_hs   = (|obuf.mask) && ordy;
   assign xfer     = stg_full && (!(|obuf.mask) || ordy);
   assign in_ready = !rst && (!stg_full || xfer);
   assign accept   = in_valid && in_ready;

   assign oval  = obuf.mask;
   assign odata = obuf.data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FILL;
         ptr      <= '0;
         stg      <= '0;
         obuf     <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         stg      <= stg_nxt;
         obuf     <= obuf_nxt;
         beat_cnt <= beat_cnt + 16'(out_hs);
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      stg_nxt   = stg;
      obuf_nxt  = obuf;

      // Transfer frees the stage first, so a same-cycle symbol lands in lane 0 (ptr is already 0 in FULL).
      if (xfer) begin
         obuf_nxt.mask = stg.mask;
         for (int i = 0; i < COLS; i++) begin
            obuf_nxt.data[i] = stg.mask[i] ? stg.data[i] : 2'b00;
         end
         stg_nxt   = '0;
         state_nxt = FILL;
      end else if (out_hs) begin
         obuf_nxt = '0;
      end

      if (accept) begin
         for (int i = 0; i < COLS; i++) begin
            if (ptr == PW'(i)) begin
               stg_nxt.data[i] = in_data;
               stg_nxt.mask[i] = 1'b1;
            end
         end
         if (ptr == LAST_LANE || in_last) begin
            state_nxt = FULL;
            ptr_nxt   = '0;
         end else begin
            ptr_nxt = ptr + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_col_lane_tx.sv
// Bench for col_lane_tx: directed scenarios plus a randomized run scored against a beat-queue model.
module tb_col_lane_tx;

   logic            clk;
   logic            rst;
   logic            in_valid, in_ready, in_last, ordy;
   logic [1:0]      in_data;
   logic [3:0]      oval;
   logic [3:0][1:0] odata;
   logic [15:0]     beat_cnt;

   logic            in_valid1, in_ready1, in_last1, ordy1;
   logic [1:0]      in_data1;
   logic [0:0]      oval1;
   logic [0:0][1:0] odata1;
   logic [15:0]     beat_cnt1;

   int total = 0;
   int bad   = 0;

   // Reference model: symbols of the open beat, and completed beats not yet taken downstream.
   logic [1:0]  part[$];
   logic [11:0] exp_q[$];
   logic [15:0] exp_cnt = 16'd0;
   logic        prev_hold = 1'b0;
   logic [3:0]  hold_oval;
   logic [7:0]  hold_odata;
   logic        m_acc, m_hs, m_rst, m_hold, m_last, exp_rdy;
   logic [1:0]  m_data;
   logic [3:0]  b_mask;
   logic [3:0][1:0] b_data;

   col_lane_tx #(.COLS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .oval(oval), .odata(odata), .ordy(ordy), .beat_cnt(beat_cnt)
   );

   col_lane_tx #(.COLS(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .in_last(in_last1), .oval(oval1), .odata(odata1), .ordy(ordy1), .beat_cnt(beat_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic put(input logic [1:0] d, input logic l, output int waits);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      waits    = 0;
      #1;
      while (!in_ready && waits < 100) begin
         @(negedge clk);
         #1;
         waits++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_valid1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 2'd3; ordy = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", in_ready); end
      @(negedge clk);
      #1;
      total++; if (oval !== 4'h0 || odata !== 8'h00) begin bad++; $display("FAIL reset_out got=%h/%h exp=0/00", oval, odata); end
      total++; if (beat_cnt !== 16'd0 || beat_cnt1 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0", beat_cnt, beat_cnt1); end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%b/%b exp=1", in_ready, in_ready1); end
   endtask

   task automatic test_stream();
      logic [1:0] s [8];
      int w, wsum;
      s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      do_reset();
      ordy = 1'b1; wsum = 0;
      for (int i = 0; i < 8; i++) begin
         put(s[i], 1'b0, w);
         wsum += w;
         if (i == 3) begin
            #1;
            total++; if (oval !== 4'h0) begin bad++; $display("FAIL stream_lat1 got=%h exp=0", oval); end
         end
         if (i == 4) begin
            #1;
            total++; if (oval !== 4'hF || odata !== 8'hE4) begin bad++; $display("FAIL stream_beat1 got=%h/%h exp=f/e4", oval, odata); end
         end
      end
      total++; if (wsum !== 0) begin bad++; $display("FAIL stream_rdy waits=%0d exp=0", wsum); end
      in_valid = 1'b0;
      #1;
      total++; if (oval !== 4'h0 || beat_cnt !== 16'd1) begin bad++; $display("FAIL stream_mid got=%h cnt=%0d exp=0 cnt=1", oval, beat_cnt); end
      @(negedge clk); #1;
      total++; if (oval !== 4'hF || odata !== 8'h1B) begin bad++; $display("FAIL stream_beat2 got=%h/%h exp=f/1b", oval, odata); end
      @(negedge clk); #1;
      total++; if (oval !== 4'h0 || beat_cnt !== 16'd2) begin bad++; $display("FAIL stream_cnt got=%h cnt=%0d exp=0 cnt=2", oval, beat_cnt); end
   endtask

   task automatic test_partial();
      int w;
      do_reset();
      ordy = 1'b1;
      put(2'd2, 1'b0, w);
      put(2'd1, 1'b1, w);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++; if (oval !== 4'b0011 || odata !== 8'h06) begin bad++; $display("FAIL partial_beat got=%h/%h exp=3/06", oval, odata); end
      @(negedge clk);
      put(2'd3, 1'b1, w);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++; if (oval !== 4'b0001 || odata !== 8'h03) begin bad++; $display("FAIL partial_next_lane0 got=%h/%h exp=1/03", oval, odata); end
   endtask

   task automatic test_backpressure();
      logic [1:0] s [12];
      int w, wsum;
      s = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
      do_reset();
      ordy = 1'b0; wsum = 0;
      for (int i = 0; i < 8; i++) begin
         put(s[i], 1'b0, w);
         wsum += w;
      end
      total++; if (wsum !== 0) begin bad++; $display("FAIL bp_fill waits=%0d exp=0", wsum); end
      in_valid = 1'b1; in_data = s[8]; in_last = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_rdy cyc=%0d got=%b exp=0", c, in_ready); end
         total++; if (oval !== 4'hF || odata !== 8'h39) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%h exp=f/39", c, oval, odata); end
         @(negedge clk); #1;
      end
      ordy = 1'b1;
      put(s[8], 1'b0, w);
      #1;
      total++; if (w !== 0 || oval !== 4'hF || odata !== 8'h5A || beat_cnt !== 16'd1) begin
         bad++; $display("FAIL bp_drain1 got=%h/%h cnt=%0d w=%0d exp=f/5a cnt=1 w=0", oval, odata, beat_cnt, w); end
      put(s[9], 1'b0, w);
      #1;
      total++; if (oval !== 4'h0 || beat_cnt !== 16'd2) begin bad++; $display("FAIL bp_drain2 got=%h cnt=%0d exp=0 cnt=2", oval, beat_cnt); end
      put(s[10], 1'b0, w);
      put(s[11], 1'b0, w);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++; if (oval !== 4'hF || odata !== 8'h0F) begin bad++; $display("FAIL bp_beat3 got=%h/%h exp=f/0f", oval, odata); end
      @(negedge clk); #1;
      total++; if (beat_cnt !== 16'd3) begin bad++; $display("FAIL bp_cnt got=%0d exp=3", beat_cnt); end
   endtask

   task automatic test_mid_reset();
      int w;
      do_reset();
      ordy = 1'b1;
      for (int i = 0; i < 4; i++) put(2'(i), 1'b0, w);
      for (int i = 0; i < 3; i++) put(2'd3, 1'b0, w);
      in_valid = 1'b0;
      #1;
      total++; if (beat_cnt !== 16'd1) begin bad++; $display("FAIL midrst_pre_cnt got=%0d exp=1", beat_cnt); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (oval !== 4'h0 || beat_cnt !== 16'd0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL midrst_state got=%h cnt=%0d rdy=%b exp=0 cnt=0 rdy=1", oval, beat_cnt, in_ready); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         total++; if (oval !== 4'h0) begin bad++; $display("FAIL midrst_discard cyc=%0d got=%h exp=0", c, oval); end
      end
      @(negedge clk);
      put(2'd3, 1'b0, w); put(2'd0, 1'b0, w); put(2'd1, 1'b0, w); put(2'd2, 1'b0, w);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++; if (oval !== 4'hF || odata !== 8'h93) begin bad++; $display("FAIL midrst_beat got=%h/%h exp=f/93", oval, odata); end
   endtask

   task automatic test_wrap();
      int w, wsum;
      do_reset();
      ordy = 1'b1; wsum = 0;
      for (int i = 0; i < 65536; i++) begin
         put(2'($urandom), 1'b1, w);
         wsum += w;
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (beat_cnt !== 16'd0 || wsum !== 0) begin bad++; $display("FAIL wrap_zero got=%0d waits=%0d exp=0", beat_cnt, wsum); end
      @(negedge clk);
      put(2'd1, 1'b1, w);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (beat_cnt !== 16'd1) begin bad++; $display("FAIL wrap_next got=%0d exp=1", beat_cnt); end
   endtask

   task automatic test_cols1();
      do_reset();
      ordy1 = 1'b1;
      in_valid1 = 1'b1; in_data1 = 2'd3; in_last1 = 1'b0;
      #1;
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL c1_rdy0 got=%b exp=1", in_ready1); end
      @(negedge clk);
      in_data1 = 2'd1; in_last1 = 1'b1;
      #1;
      total++; if (in_ready1 !== 1'b1 || oval1 !== 1'b0) begin bad++; $display("FAIL c1_rdy1 got=%b/%b exp=1/0", in_ready1, oval1); end
      @(negedge clk);
      in_valid1 = 1'b0;
      #1;
      total++; if (oval1 !== 1'b1 || odata1 !== 2'd3) begin bad++; $display("FAIL c1_beat1 got=%b/%0d exp=1/3", oval1, odata1); end
      @(negedge clk); #1;
      total++; if (oval1 !== 1'b1 || odata1 !== 2'd1) begin bad++; $display("FAIL c1_beat2 got=%b/%0d exp=1/1", oval1, odata1); end
      @(negedge clk); #1;
      total++; if (oval1 !== 1'b0 || beat_cnt1 !== 16'd2) begin bad++; $display("FAIL c1_cnt got=%b cnt=%0d exp=0 cnt=2", oval1, beat_cnt1); end
   endtask

   task automatic test_random();
      int n;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 399) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 2'($urandom);
         in_last  = ($urandom_range(0, 4) == 0);
         ordy     = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; ordy = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #3;
      total++; if (exp_q.size() != 0 || oval !== 4'h0) begin
         bad++; $display("FAIL rand_drain left=%0d oval=%h exp=0/0", exp_q.size(), oval); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; in_last = 1'b0; ordy = 1'b0;
      in_valid1 = 1'b0; in_data1 = 2'd0; in_last1 = 1'b0; ordy1 = 1'b0;
      fork
         forever begin
            @(negedge clk);
            #2;
            exp_rdy = !rst && !(exp_q.size() >= 2 && !ordy);
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy); end
            total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL mon_beat_cnt t=%0t got=%0d exp=%0d", $time, beat_cnt, exp_cnt); end
            if (oval === 4'h0) begin
               total++; if (odata !== 8'h00) begin bad++; $display("FAIL mon_idle_data t=%0t got=%h exp=00", $time, odata); end
            end else begin
               total++;
               if (exp_q.size() == 0) begin bad++; $display("FAIL mon_beat t=%0t got=%h/%h exp=none", $time, oval, odata); end
               else if ({oval, odata} !== exp_q[0]) begin
                  bad++; $display("FAIL mon_beat t=%0t got=%h/%h exp=%h/%h", $time, oval, odata, exp_q[0][11:8], exp_q[0][7:0]); end
            end
            if (prev_hold) begin
               total++; if (oval !== hold_oval || odata !== hold_odata) begin
                  bad++; $display("FAIL mon_hold t=%0t got=%h/%h exp=%h/%h", $time, oval, odata, hold_oval, hold_odata); end
            end
            m_acc  = in_valid && in_ready;
            m_hs   = (|oval) && ordy;
            m_hold = (|oval) && !ordy;
            m_rst  = rst;
            m_data = in_data;
            m_last = in_last;
            hold_oval  = oval;
            hold_odata = odata;
            @(posedge clk);
            if (m_rst) begin
               exp_q.delete();
               part.delete();
               exp_cnt = 16'd0;
            end else begin
               if (m_hs) begin
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  exp_cnt = exp_cnt + 16'd1;
               end
               if (m_acc) begin
                  part.push_back(m_data);
                  if (part.size() == 4 || m_last) begin
                     b_mask = '0;
                     b_data = '0;
                     for (int i = 0; i < part.size(); i++) begin
                        b_mask[i] = 1'b1;
                        b_data[i] = part[i];
                     end
                     exp_q.push_back({b_mask, b_data});
                     part.delete();
                  end
               end
            end
            prev_hold = m_hold && !m_rst;
         end
      join_none
      test_reset();
      test_stream();
      test_partial();
      test_backpressure();
      test_mid_reset();
      test_cols1();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
